// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Divisor arithmetic is done at 32 bits and narrowed by the caller.
package clock_divider_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;
  localparam int unsigned DIV_MIN           = 2;

  typedef logic [DIV_WIDTH_DEFAULT-1:0] div_t;
  typedef logic [31:0]                  div_calc_t;

  function automatic div_calc_t clamp_div(input div_calc_t v);
    return (v < div_calc_t'(DIV_MIN)) ? div_calc_t'(DIV_MIN) : v;
  endfunction

  // ceil(d/2) without needing a wider intermediate
  function automatic div_calc_t half_up(input div_calc_t d);
    return (d >> 1) + div_calc_t'(d[0]);
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Bundle of the divider's per-channel request and status signals.
interface multi_clock_divider_if #(
  parameter int unsigned par_ch_count  = 4,
  parameter int unsigned par_div_width = 16
);
  logic [par_ch_count-1:0][par_div_width-1:0] div_value;
  logic [par_ch_count-1:0]                    div_load;
  logic                                       sync;
  logic [par_ch_count-1:0]                    clk_div;
  logic [par_ch_count-1:0]                    ce_rise;
  logic [par_ch_count-1:0]                    rst_div;
  logic [par_ch_count-1:0]                    div_busy;

  modport master (
    output div_value, div_load, sync,
    input  clk_div, ce_rise, rst_div, div_busy
  );

  modport slave (
    input  div_value, div_load, sync,
    output clk_div, ce_rise, rst_div, div_busy
  );
endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: counter 0..D-1, low for ceil(D/2) cycles, then high.
// Divisor changes are deferred to the wrap so a period is never cut short.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int unsigned par_div_width   = 16,
  parameter int unsigned par_div_default = 1000,
  parameter int unsigned par_rst_cycles  = 1
) (
  input  logic                     i_clk_mhz,
  input  logic                     i_rst_mhz,
  input  logic                     i_sync,
  input  logic [par_div_width-1:0] i_div_value,
  input  logic                     i_div_load,
  output logic                     o_clk_div,
  output logic                     o_ce_rise,
  output logic                     o_rst_div,
  output logic                     o_div_busy
);

  localparam int unsigned RISE_W = $clog2(par_rst_cycles + 2);
  localparam logic [RISE_W-1:0] RISE_TGT = RISE_W'(par_rst_cycles);
  localparam logic [RISE_W-1:0] RISE_ONE = RISE_W'(1);
  localparam logic [par_div_width-1:0] CNT_ONE = par_div_width'(1);
  localparam logic [par_div_width-1:0] DIV_RESET =
    par_div_width'(clamp_div(div_calc_t'(par_div_default)));

  logic [par_div_width-1:0] r_cnt, r_div, r_pend;
  logic                     r_clk, r_ce, r_rst, r_busy;
  logic [RISE_W-1:0]        r_rise;

  logic                     w_wrap, w_clk_nxt, w_ce_nxt;
  logic [par_div_width-1:0] w_cnt_nxt, w_half, w_load_val;

  always_comb begin
    w_wrap     = (r_cnt == r_div - CNT_ONE);
    w_cnt_nxt  = w_wrap ? '0 : r_cnt + CNT_ONE;
    // half of the old divisor is safe here: a wrapped count of 0 is always low
    w_half     = par_div_width'(half_up(div_calc_t'(r_div)));
    w_clk_nxt  = (w_cnt_nxt >= w_half);
    w_ce_nxt   = (w_cnt_nxt == w_half);
    w_load_val = par_div_width'(clamp_div(div_calc_t'(i_div_value)));
  end

  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) begin
      r_cnt  <= '0;
      r_div  <= DIV_RESET;
      r_pend <= DIV_RESET;
      r_clk  <= 1'b0;
      r_ce   <= 1'b0;
      r_busy <= 1'b0;
      r_rst  <= 1'b1;
      r_rise <= '0;
    end else if (i_sync) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_ce   <= 1'b0;
      r_div  <= r_pend;
      r_busy <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_clk <= w_clk_nxt;
      r_ce  <= w_ce_nxt;
      if (w_wrap) begin
        r_div  <= r_pend;
        r_busy <= 1'b0;
      end
      // a load in the wrap cycle lands after the swap, so it waits a period
      if (i_div_load) begin
        r_pend <= w_load_val;
        r_busy <= 1'b1;
      end
      if (w_ce_nxt && (r_rise < RISE_TGT)) begin
        r_rise <= r_rise + RISE_ONE;
      end
      if (r_clk && !w_clk_nxt && (r_rise == RISE_TGT)) begin
        r_rst <= 1'b0;
      end
    end
  end

  assign o_clk_div  = r_clk;
  assign o_ce_rise  = r_ce;
  assign o_rst_div  = r_rst;
  assign o_div_busy = r_busy;

endmodule

// File: rtl/multi_clock_divider.sv
// Top: packs per-channel ports and fans i_sync out to every channel.
module multi_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned par_ch_count    = 4,
  parameter int unsigned par_div_width   = DIV_WIDTH_DEFAULT,
  parameter int unsigned par_div_default = 1000,
  parameter int unsigned par_rst_cycles  = 1
) (
  input  logic                                       i_clk_mhz,
  input  logic                                       i_rst_mhz,
  input  logic [par_ch_count-1:0][par_div_width-1:0] i_div_value,
  input  logic [par_ch_count-1:0]                    i_div_load,
  input  logic                                       i_sync,
  output logic [par_ch_count-1:0]                    o_clk_div,
  output logic [par_ch_count-1:0]                    o_ce_rise,
  output logic [par_ch_count-1:0]                    o_rst_div,
  output logic [par_ch_count-1:0]                    o_div_busy
);

  for (genvar k = 0; k < par_ch_count; k++) begin : g_ch
    clock_divider_channel #(
      .par_div_width  (par_div_width),
      .par_div_default(par_div_default),
      .par_rst_cycles (par_rst_cycles)
    ) u_ch (
      .i_clk_mhz  (i_clk_mhz),
      .i_rst_mhz  (i_rst_mhz),
      .i_sync     (i_sync),
      .i_div_value(i_div_value[k]),
      .i_div_load (i_div_load[k]),
      .o_clk_div  (o_clk_div[k]),
      .o_ce_rise  (o_ce_rise[k]),
      .o_rst_div  (o_rst_div[k]),
      .o_div_busy (o_div_busy[k])
    );
  end

endmodule
